// File: rtl/crc8_frame_checker.sv
// CRC-8 frame checker: folds data bytes into a running CRC, compares it with the
// trailing CRC byte, and holds a pass/fail result plus saturating frame counters.
module crc8_frame_checker #(
    parameter logic [7:0] POLY    = 8'h07,
    parameter logic [7:0] INIT    = 8'h00,
    parameter int         MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_ok,
    output logic [7:0]  res_crc,
    output logic [7:0]  res_len,
    output logic        res_len_err,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESULT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  len_q, len_d;
    logic        res_ok_q, res_ok_d;
    logic [7:0]  res_crc_q, res_crc_d;
    logic [7:0]  res_len_q, res_len_d;
    logic        res_len_err_q, res_len_err_d;
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        accept;
    logic        len_err_w;
    logic        frame_ok_w;
    logic [7:0]  crc_next_w;

    // MSB-first, non-reflected byte update, fully unrolled in one cycle.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ POLY;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign in_ready   = (state_q != S_RESULT);
    assign accept     = in_valid && in_ready;
    assign crc_next_w = crc8_byte(crc_q, in_data);
    assign len_err_w  = (int'(len_q) > MAX_LEN);
    assign frame_ok_w = (crc_q == in_data) && !len_err_w;

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        res_ok_d      = res_ok_q;
        res_crc_d     = res_crc_q;
        res_len_d     = res_len_q;
        res_len_err_d = res_len_err_q;
        ok_cnt_d      = ok_cnt_q;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    if (in_last) begin
                        // The CRC byte is only compared, never folded in or counted.
                        res_crc_d     = crc_q;
                        res_len_d     = len_q;
                        res_len_err_d = len_err_w;
                        res_ok_d      = frame_ok_w;
                        if (frame_ok_w) begin
                            if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
                        end else begin
                            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        end
                        state_d = S_RESULT;
                    end else begin
                        crc_d = crc_next_w;
                        if (len_q != 8'hFF) len_d = len_q + 8'd1;
                        state_d = S_DATA;
                    end
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    crc_d   = INIT;
                    len_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                crc_d   = INIT;
                len_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            crc_q         <= INIT;
            len_q         <= 8'd0;
            res_ok_q      <= 1'b0;
            res_crc_q     <= 8'h00;
            res_len_q     <= 8'h00;
            res_len_err_q <= 1'b0;
            ok_cnt_q      <= 16'd0;
            err_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            res_ok_q      <= res_ok_d;
            res_crc_q     <= res_crc_d;
            res_len_q     <= res_len_d;
            res_len_err_q <= res_len_err_d;
            ok_cnt_q      <= ok_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign res_valid   = (state_q == S_RESULT);
    assign res_ok      = res_ok_q;
    assign res_crc     = res_crc_q;
    assign res_len     = res_len_q;
    assign res_len_err = res_len_err_q;
    assign ok_cnt      = ok_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker: a default instance and a MAX_LEN=4
// instance share the stimulus; expected results flow through a scoreboard queue.
module tb_crc8_frame_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, res_ready;
    logic [7:0]  in_data;

    logic        in_ready, res_valid, res_ok, res_len_err;
    logic [7:0]  res_crc, res_len;
    logic [15:0] ok_cnt, err_cnt;

    logic        in_ready2, res_valid2, res_ok2, res_len_err2;
    logic [7:0]  res_crc2, res_len2;
    logic [15:0] ok_cnt2, err_cnt2;

    always #5 clk = ~clk;

    crc8_frame_checker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .res_valid(res_valid),
        .res_ready(res_ready), .res_ok(res_ok), .res_crc(res_crc),
        .res_len(res_len), .res_len_err(res_len_err), .ok_cnt(ok_cnt),
        .err_cnt(err_cnt)
    );

    crc8_frame_checker #(.MAX_LEN(4)) dut_len (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .res_valid(res_valid2),
        .res_ready(res_ready), .res_ok(res_ok2), .res_crc(res_crc2),
        .res_len(res_len2), .res_len_err(res_len_err2), .ok_cnt(ok_cnt2),
        .err_cnt(err_cnt2)
    );

    typedef struct packed {
        logic [7:0] crc;
        logic [7:0] len;
        logic       ok;
        logic       ok2;
        logic       lerr2;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  fr [0:15];
    int unsigned ok_exp = 0, err_exp = 0, ok2_exp = 0, err2_exp = 0;

    function automatic logic [7:0] ref_crc(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ fr[i];
            for (int b = 0; b < 8; b++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic acc;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        assert (done) else begin
            n_fail++;
            $error("FAIL accept_timeout observed=0 expected=1");
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] crcb);
        exp_t e;
        e.crc   = ref_crc(n);
        e.len   = n[7:0];
        e.ok    = (e.crc == crcb);
        e.ok2   = (e.crc == crcb) && (n <= 4);
        e.lerr2 = (n > 4);
        sb.push_back(e);
        for (int i = 0; i < n; i++) send_byte(fr[i], 1'b0);
        send_byte(crcb, 1'b1);
    endtask

    // Must run at the negedge right after the last byte's accepting edge.
    task automatic check_result(input string tag);
        chk({tag, "_valid"}, 16'(res_valid), 16'd1);
        chk({tag, "_valid2"}, 16'(res_valid2), 16'd1);
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            last_e = sb.pop_front();
            if (last_e.ok) ok_exp++; else err_exp++;
            if (last_e.ok2) ok2_exp++; else err2_exp++;
            chk({tag, "_ok"}, 16'(res_ok), 16'(last_e.ok));
            chk({tag, "_crc"}, 16'(res_crc), 16'(last_e.crc));
            chk({tag, "_len"}, 16'(res_len), 16'(last_e.len));
            chk({tag, "_lerr"}, 16'(res_len_err), 16'd0);
            chk({tag, "_okcnt"}, ok_cnt, 16'(ok_exp));
            chk({tag, "_errcnt"}, err_cnt, 16'(err_exp));
            chk({tag, "_ok2"}, 16'(res_ok2), 16'(last_e.ok2));
            chk({tag, "_lerr2"}, 16'(res_len_err2), 16'(last_e.lerr2));
            chk({tag, "_crc2"}, 16'(res_crc2), 16'(last_e.crc));
            chk({tag, "_okcnt2"}, ok_cnt2, 16'(ok2_exp));
            chk({tag, "_errcnt2"}, err_cnt2, 16'(err2_exp));
        end
        $display("frame %s: crc=%02h len=%0d ok=%0b ok_cnt=%0d err_cnt=%0d",
                 tag, res_crc, res_len, res_ok, ok_cnt, err_cnt);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_cons_valid"}, 16'(res_valid), 16'd0);
        chk({tag, "_cons_ready"}, 16'(in_ready), 16'd1);
    endtask

    task automatic load_123456789();
        for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        chk({tag, "_res_valid"}, 16'(res_valid), 16'd0);
        chk({tag, "_res_ok"}, 16'(res_ok), 16'd0);
        chk({tag, "_res_crc"}, 16'(res_crc), 16'h00);
        chk({tag, "_res_len"}, 16'(res_len), 16'h00);
        chk({tag, "_res_len_err"}, 16'(res_len_err), 16'd0);
        chk({tag, "_ok_cnt"}, ok_cnt, 16'd0);
        chk({tag, "_err_cnt"}, err_cnt, 16'd0);
        chk({tag, "_err_cnt2"}, err_cnt2, 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame "123456789" with CRC F4
        load_123456789();
        send_frame(9, 8'hF4);
        check_result("good9");
        chk("good9_crc_const", 16'(res_crc), 16'h00F4);
        chk("good9_len_const", 16'(res_len), 16'd9);
        chk("good9_ok_const", 16'(res_ok), 16'd1);
        chk("good9_okcnt_const", ok_cnt, 16'd1);
        consume("good9");

        // Bad frame 01 / 06
        fr[0] = 8'h01;
        send_frame(1, 8'h06);
        check_result("bad01");
        chk("bad01_crc_const", 16'(res_crc), 16'h0007);
        chk("bad01_ok_const", 16'(res_ok), 16'd0);
        chk("bad01_errcnt_const", err_cnt, 16'd1);
        consume("bad01");

        // Good frame FF / F3
        fr[0] = 8'hFF;
        send_frame(1, 8'hF3);
        check_result("ffF3");
        chk("ffF3_ok_const", 16'(res_ok), 16'd1);
        consume("ffF3");

        // Single-byte frames
        send_frame(0, 8'h00);
        check_result("single00");
        chk("single00_ok_const", 16'(res_ok), 16'd1);
        chk("single00_len_const", 16'(res_len), 16'd0);
        consume("single00");
        send_frame(0, 8'h5A);
        check_result("single5A");
        chk("single5A_ok_const", 16'(res_ok), 16'd0);
        consume("single5A");

        // Backpressure: result held for 5 cycles while next frame's byte waits
        fr[0] = 8'h10; fr[1] = 8'h20;
        send_frame(2, ref_crc(2));
        check_result("bpA");
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 16'(in_ready), 16'd0);
            chk("bp_valid", 16'(res_valid), 16'd1);
            chk("bp_crc_hold", 16'(res_crc), 16'(last_e.crc));
            chk("bp_len_hold", 16'(res_len), 16'(last_e.len));
        end
        consume("bpA");
        fr[0] = 8'hA5; fr[1] = 8'h3C; fr[2] = 8'hC3;
        send_frame(3, ref_crc(3));
        check_result("bpB");
        chk("bpB_ok_const", 16'(res_ok), 16'd1);
        consume("bpB");

        // Length limit: 5 data bytes with correct CRC; MAX_LEN=4 instance flags it
        for (int i = 0; i < 5; i++) fr[i] = 8'(i + 1);
        send_frame(5, ref_crc(5));
        check_result("len5");
        chk("len5_len2_const", 16'(res_len2), 16'd5);
        chk("len5_lerr2_const", 16'(res_len_err2), 16'd1);
        chk("len5_ok2_const", 16'(res_ok2), 16'd0);
        consume("len5");

        // Reset mid-frame after 3 data bytes
        load_123456789();
        for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        ok_exp = 0; err_exp = 0; ok2_exp = 0; err2_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(9, 8'hF4);
        check_result("post_rst");
        chk("post_rst_okcnt_const", ok_cnt, 16'd1);
        chk("post_rst_errcnt_const", err_cnt, 16'd0);
        consume("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Receive-side companion to the combinational `crc` byte encoder. The block accepts a byte stream over a valid/ready handshake and treats the final byte of each frame as the transmitted CRC-8. It computes the running CRC over the data bytes, compares it with the trailing byte, and presents a held pass/fail result with the frame length. It also maintains saturating good-frame and bad-frame counters for status readout.

## Interface
- `POLY`, default 8'h07: CRC-8 generator polynomial, with the implicit x^8 omitted.
- `INIT`, default 8'h00: CRC register value at the start of each frame.
- `MAX_LEN`, default 255: maximum number of data bytes allowed, excluding the CRC byte.
- `clk` input, 1 bit: single clock; all logic updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` and `in_last` are valid.
- `in_ready` output, 1 bit: block can accept a byte this cycle.
- `in_data` input, 8 bits: stream byte.
- `in_last` input, 1 bit: current byte is the frame's CRC byte (end of frame).
- `res_valid` output, 1 bit: result is valid and is held until it is consumed.
- `res_ready` input, 1 bit: downstream consumes the result.
- `res_ok` output, 1 bit: computed CRC equals the received CRC and no length error occurred.
- `res_crc` output, 8 bits: computed CRC over the data bytes.
- `res_len` output, 8 bits: data byte count, saturating at 255.
- `res_len_err` output, 1 bit: data byte count exceeded `MAX_LEN`.
- `ok_cnt` output, 16 bits: count of frames with `res_ok`=1, saturating at 16'hFFFF.
- `err_cnt` output, 16 bits: count of frames with `res_ok`=0, saturating at 16'hFFFF.

## Operation
- A byte is accepted in any cycle where `in_valid` and `in_ready` are both 1.
- CRC update for each accepted non-last byte: MSB-first, non-reflected, no final XOR.
  - Per byte: `c = c ^ in_data`; then 8 iterations of: if `c[7]`, `c = (c<<1) ^ POLY`, else `c = c<<1`.
  - This is bit-identical to `crc` for a single byte when `INIT`=0.
- States:
  - IDLE: no frame in progress; `crc_reg`=`INIT`, `len`=0.
    - First accepted byte with `in_last`=0 → DATA.
    - First accepted byte with `in_last`=1 → RESULT.
  - DATA: update the CRC and increment `len` (saturating at 255) on each accepted non-last byte.
    - Accepted byte with `in_last`=1 → RESULT.
  - RESULT: `res_valid`=1 and `in_ready`=0.
    - `res_valid && res_ready` → IDLE, with `crc_reg` reloaded to `INIT` and `len` cleared.
- On the last byte, the block latches:
  - `res_crc` = `crc_reg`
  - `res_len` = `len`
  - `res_len_err` = (`len` > `MAX_LEN`)
  - `res_ok` = (`crc_reg` == `in_data`) && !`res_len_err`
- The CRC byte itself is never folded into the CRC and never counted in `len`.
- `in_ready` = !`res_valid`. There is no combinational path from `res_ready` to `in_ready`.
- `ok_cnt` or `err_cnt` increments once per frame, in the same edge that sets `res_valid`. Both counters saturate and are never cleared except by reset.
- Single-byte frame (`in_last` on the first byte): `res_crc`=`INIT`, `res_len`=0, and `res_ok`=1 iff `in_data`==`INIT`.
- `in_valid` while `in_ready`=0: the byte is not accepted. The source must hold it.
- Reset asserted mid-frame or during RESULT: the partial frame and any pending result are discarded, and nothing is counted.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`=1.
  - `res_valid`=0, `res_ok`=0, `res_crc`=8'h00, `res_len`=8'h00, `res_len_err`=0.
  - `ok_cnt`=0, `err_cnt`=0.
- The byte-wise CRC is computed combinationally within one cycle, giving a throughput of 1 byte/cycle in IDLE and DATA.
- Latency: if the last byte is accepted at edge N, `res_valid` and the result fields are visible after edge N, and the counters update at edge N.
- Consume: if `res_ready`=1 at edge M while `res_valid`=1, then `res_valid`=0 and `in_ready`=1 after M.
  - The next frame's first byte can be accepted at edge M+1.
  - Minimum frame gap is therefore 1 cycle.
- Result fields stay stable while `res_valid`=1 and `res_ready`=0.

## Test plan
- Good frame "123456789" (31 32 33 34 35 36 37 38 39) followed by 8'hF4 with `in_last`=1:
  - Expect `res_ok`=1, `res_crc`=8'hF4, `res_len`=9, `ok_cnt`=1.
  - `res_valid` rises the cycle after the last byte is accepted.
- Bad frame: bytes 8'h01 then 8'h06 (`in_last`):
  - Expect `res_crc`=8'h07, `res_ok`=0, `err_cnt`=1.
  - Repeat with 8'hFF then 8'hF3 (`in_last`): expect `res_ok`=1.
- Single-byte frames: 8'h00 with `in_last` → `res_ok`=1, `res_len`=0; 8'h5A with `in_last` → `res_ok`=0.
- Backpressure:
  - Hold `res_ready`=0 for 5 cycles with `in_valid`=1: `in_ready` stays 0, the result is stable, and no byte is consumed.
  - Raise `res_ready`: the next frame is accepted one cycle later and yields the correct CRC.
- Length limit with `MAX_LEN`=4: 5 data bytes plus the correct CRC → `res_len`=5, `res_len_err`=1, `res_ok`=0, `err_cnt` increments.
- Reset mid-frame: assert `rst_n`=0 after 3 data bytes.
  - All outputs return to their reset values and both counters read 0.
  - The following good frame passes normally.
